irq_ctrl: RTL

Three-line interrupt controller sitting directly upstream of the `main` CPU core: it synchronises the raw `ir0`..`ir2` request lines, latches rising edges as pending requests, applies a CPU-writable mask and fixed priority, and presents one request at a time with a vector address to the core. It tracks in-service levels so only a strictly higher-priority line can preempt a running handler, and it retires levels on `eret`.

---
 rtl/irq_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Three-line interrupt controller: synchronises raw requests, latches edges as
// pending, applies mask/enable and fixed priority, and hands one vector at a time to the core.
module irq_ctrl #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0020
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ir0,
    input  logic        ir1,
    input  logic        ir2,
    input  logic        int_en,
    input  logic        mask_we,
    input  logic [2:0]  mask_wdata,
    input  logic        int_ack,
    input  logic        eret,
    output logic        int_req,
    output logic [1:0]  int_id,
    output logic [31:0] int_vector,
    output logic [2:0]  pending,
    output logic [2:0]  in_service,
    output logic [2:0]  lost
);

    localparam int unsigned N_LINES = 3;
    localparam int unsigned ID_W    = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     int_id_q, int_id_d;
    logic [N_LINES-1:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [N_LINES-1:0]  pending_q, pending_d;
    logic [N_LINES-1:0]  in_service_q, in_service_d;
    logic [N_LINES-1:0]  lost_q, lost_d;
    logic [N_LINES-1:0]  mask_q, mask_d;

    logic [N_LINES-1:0]  rise_c;
    logic [N_LINES-1:0]  blocked_c;
    logic [N_LINES-1:0]  elig_c;
    logic [N_LINES-1:0]  ack_vec_c;
    logic [N_LINES-1:0]  eret_clr_c;
    logic                ack_fire_c;

    // Edge detection, eligibility and handshake decode
    always_comb begin
        rise_c       = s2_q & ~s3_q;
        blocked_c[0] = in_service_q[0];
        blocked_c[1] = |in_service_q[1:0];
        blocked_c[2] = |in_service_q;
        elig_c       = pending_q & mask_q & {N_LINES{int_en}} & ~blocked_c;
        ack_fire_c   = (state_q == ST_REQ) & int_ack;
        ack_vec_c    = ack_fire_c ? N_LINES'(3'b001 << int_id_q) : '0;
        // lowest set index is the highest-priority level in service
        eret_clr_c   = eret ? (in_service_q & (~in_service_q + N_LINES'(1))) : '0;
    end

    // Datapath next-state: eret retires before ack sets, rise beats ack-clear
    always_comb begin
        s1_d         = {ir2, ir1, ir0};
        s2_d         = s1_q;
        s3_d         = s2_q;
        in_service_d = (in_service_q & ~eret_clr_c) | ack_vec_c;
        pending_d    = (pending_q & ~ack_vec_c) | rise_c;
        lost_d       = (mask_we ? '0 : lost_q) | (rise_c & pending_q & ~ack_vec_c);
        mask_d       = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            lost_q       <= '0;
            mask_q       <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            lost_q       <= lost_d;
            mask_q       <= mask_d;
        end
    end

    // FSM state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            int_id_q <= '0;
        end else begin
            state_q  <= state_d;
            int_id_q <= int_id_d;
        end
    end

    // FSM next-state: int_id is frozen while a request is presented
    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|elig_c) begin
                    state_d = ST_REQ;
                    if (elig_c[0])      int_id_d = ID_W'(0);
                    else if (elig_c[1]) int_id_d = ID_W'(1);
                    else                int_id_d = ID_W'(2);
                end
            end
            ST_REQ: begin
                if (ack_fire_c || !elig_c[int_id_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM / register outputs
    always_comb begin
        int_req    = (state_q == ST_REQ);
        int_id     = int_id_q;
        int_vector = VEC_BASE + 32'(int_id_q) * VEC_STRIDE;
        pending    = pending_q;
        in_service = in_service_q;
        lost       = lost_q;
    end

endmodule
